// File: rtl/memory_stage.sv
// Pipeline M stage: latches execute results, runs loads/stores over a req/ack data port,
// stalls upstream while an access is outstanding, and resolves the branch decision.
module memory_stage #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       alu_out_e,
    input  logic [31:0]       write_data_e,
    input  logic [4:0]        write_reg_e,
    input  logic              reg_write_e,
    input  logic              mem_to_reg_e,
    input  logic              mem_write_e,
    input  logic              branch_e,
    input  logic              zero_e,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_m,
    output logic [31:0]       alu_out_m,
    output logic [31:0]       read_data_m,
    output logic [4:0]        write_reg_m,
    output logic              reg_write_m,
    output logic              mem_to_reg_m,
    output logic              pc_src_m,
    output logic              addr_err_m
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    logic [31:0] alu_q;
    logic [31:0] wdata_q;
    logic [4:0]  wreg_q;
    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic        mem_write_q;
    logic        branch_q;
    logic        zero_q;
    logic [31:0] read_data_q;
    logic        addr_err_q;
    logic        mem_op;
    logic        aligned;

    assign mem_op  = mem_to_reg_q | mem_write_q;
    assign aligned = (alu_q[1:0] == 2'b00);

    // The stage only releases upstream in DONE or for a non-memory op in IDLE.
    always_comb begin
        stall_m = 1'b0;
        if (state_q == StBusy) begin
            stall_m = 1'b1;
        end else if (state_q == StIdle && mem_op) begin
            stall_m = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            alu_q        <= '0;
            wdata_q      <= '0;
            wreg_q       <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            zero_q       <= 1'b0;
            read_data_q  <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            if (!stall_m) begin
                alu_q        <= alu_out_e;
                wdata_q      <= write_data_e;
                wreg_q       <= write_reg_e;
                reg_write_q  <= reg_write_e;
                mem_to_reg_q <= mem_to_reg_e;
                mem_write_q  <= mem_write_e;
                branch_q     <= branch_e;
                zero_q       <= zero_e;
            end
            unique case (state_q)
                StIdle: begin
                    if (mem_op) begin
                        if (aligned) begin
                            state_q <= StBusy;
                        end else begin
                            // Misaligned ops skip the bus entirely and report the error.
                            state_q     <= StDone;
                            addr_err_q  <= 1'b1;
                            read_data_q <= '0;
                        end
                    end
                end
                StBusy: begin
                    if (dmem_ack) begin
                        if (!mem_write_q) begin
                            read_data_q <= dmem_rdata;
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q    <= StIdle;
                    addr_err_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dmem_req     = (state_q == StBusy);
    assign dmem_we      = mem_write_q;
    assign dmem_addr    = {alu_q[ADDR_W-1:2], 2'b00};
    assign dmem_wdata   = wdata_q;
    assign alu_out_m    = alu_q;
    assign read_data_m  = read_data_q;
    assign write_reg_m  = wreg_q;
    assign reg_write_m  = reg_write_q & ~stall_m;
    assign mem_to_reg_m = mem_to_reg_q;
    assign pc_src_m     = branch_q & zero_q;
    assign addr_err_m   = addr_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, load/store handshakes, misalignment,
// branch resolution and asynchronous reset in the middle of an access.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_out_e = '0;
    logic [31:0] write_data_e = '0;
    logic [4:0]  write_reg_e = '0;
    logic        reg_write_e = 1'b0;
    logic        mem_to_reg_e = 1'b0;
    logic        mem_write_e = 1'b0;
    logic        branch_e = 1'b0;
    logic        zero_e = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        stall_m;
    logic [31:0] alu_out_m;
    logic [31:0] read_data_m;
    logic [4:0]  write_reg_m;
    logic        reg_write_m;
    logic        mem_to_reg_m;
    logic        pc_src_m;
    logic        addr_err_m;

    int tests = 0;
    int fails = 0;
    int stall_cnt;
    int req_cnt;

    memory_stage #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_out_e    (alu_out_e),
        .write_data_e (write_data_e),
        .write_reg_e  (write_reg_e),
        .reg_write_e  (reg_write_e),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_write_e  (mem_write_e),
        .branch_e     (branch_e),
        .zero_e       (zero_e),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall_m      (stall_m),
        .alu_out_m    (alu_out_m),
        .read_data_m  (read_data_m),
        .write_reg_m  (write_reg_m),
        .reg_write_m  (reg_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .pc_src_m     (pc_src_m),
        .addr_err_m   (addr_err_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the edge before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
        stall_cnt += int'(stall_m);
        req_cnt   += int'(dmem_req);
    endtask

    task automatic bubble();
        alu_out_e    = '0;
        write_data_e = '0;
        write_reg_e  = '0;
        reg_write_e  = 1'b0;
        mem_to_reg_e = 1'b0;
        mem_write_e  = 1'b0;
        branch_e     = 1'b0;
        zero_e       = 1'b0;
    endtask

    initial begin
        stall_cnt = 0;
        req_cnt   = 0;
        // Reset state
        #12;
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_stall", {31'b0, stall_m}, 32'd0);
        check("rst_alu", alu_out_m, 32'd0);
        check("rst_rdata", read_data_m, 32'd0);
        check("rst_pcsrc", {31'b0, pc_src_m}, 32'd0);
        rst = 1'b0;
        tick();

        // ALU op passes in one cycle
        reg_write_e = 1'b1;
        alu_out_e   = 32'h1234;
        write_reg_e = 5'd5;
        tick();
        bubble();
        check("alu_out", alu_out_m, 32'h1234);
        check("alu_wreg", {27'b0, write_reg_m}, 32'd5);
        check("alu_regwr", {31'b0, reg_write_m}, 32'd1);
        check("alu_stall", {31'b0, stall_m}, 32'd0);
        tick();

        // Load at 0x40, ack in third BUSY cycle
        alu_out_e    = 32'h40;
        mem_to_reg_e = 1'b1;
        reg_write_e  = 1'b1;
        write_reg_e  = 5'd3;
        stall_cnt = 0;
        req_cnt   = 0;
        tick();
        bubble();
        check("ld_idle_req", {31'b0, dmem_req}, 32'd0);
        check("ld_idle_regwr", {31'b0, reg_write_m}, 32'd0);
        tick();
        check("ld_busy_we", {31'b0, dmem_we}, 32'd0);
        check("ld_busy_addr", dmem_addr, 32'h40);
        check("ld_busy_regwr", {31'b0, reg_write_m}, 32'd0);
        tick();
        check("ld_busy2_req", {31'b0, dmem_req}, 32'd1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        check("ld_done_rdata", read_data_m, 32'hDEADBEEF);
        check("ld_done_regwr", {31'b0, reg_write_m}, 32'd1);
        check("ld_done_wreg", {27'b0, write_reg_m}, 32'd3);
        check("ld_stall_cycles", stall_cnt, 32'd4);
        check("ld_req_cycles", req_cnt, 32'd3);
        tick();
        check("ld_after_stall", {31'b0, stall_m}, 32'd0);
        check("ld_after_regwr", {31'b0, reg_write_m}, 32'd0);

        // Store 0xCAFEF00D at 0x80, immediate ack
        alu_out_e    = 32'h80;
        write_data_e = 32'hCAFEF00D;
        mem_write_e  = 1'b1;
        stall_cnt = 0;
        req_cnt   = 0;
        tick();
        bubble();
        tick();
        check("st_busy_we", {31'b0, dmem_we}, 32'd1);
        check("st_busy_wdata", dmem_wdata, 32'hCAFEF00D);
        check("st_busy_addr", dmem_addr, 32'h80);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("st_done_req", {31'b0, dmem_req}, 32'd0);
        check("st_rdata_kept", read_data_m, 32'hDEADBEEF);
        check("st_stall_cycles", stall_cnt, 32'd2);
        check("st_req_cycles", req_cnt, 32'd1);
        tick();
        check("st_after_req", {31'b0, dmem_req}, 32'd0);

        // Misaligned load at 0x42
        alu_out_e    = 32'h42;
        mem_to_reg_e = 1'b1;
        reg_write_e  = 1'b1;
        stall_cnt = 0;
        req_cnt   = 0;
        tick();
        bubble();
        check("mis_idle_err", {31'b0, addr_err_m}, 32'd0);
        tick();
        check("mis_done_err", {31'b0, addr_err_m}, 32'd1);
        check("mis_done_rdata", read_data_m, 32'd0);
        check("mis_done_stall", {31'b0, stall_m}, 32'd0);
        tick();
        check("mis_after_err", {31'b0, addr_err_m}, 32'd0);
        check("mis_stall_cycles", stall_cnt, 32'd1);
        check("mis_req_cycles", req_cnt, 32'd0);

        // Branch resolution
        branch_e = 1'b1;
        zero_e   = 1'b1;
        tick();
        check("br_taken", {31'b0, pc_src_m}, 32'd1);
        zero_e = 1'b0;
        tick();
        check("br_not_taken", {31'b0, pc_src_m}, 32'd0);
        bubble();
        tick();

        // Reset in the middle of a load
        alu_out_e    = 32'h100;
        mem_to_reg_e = 1'b1;
        reg_write_e  = 1'b1;
        tick();
        bubble();
        tick();
        check("rb_busy_req", {31'b0, dmem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rb_req_drop", {31'b0, dmem_req}, 32'd0);
        check("rb_alu_zero", alu_out_m, 32'd0);
        check("rb_stall_zero", {31'b0, stall_m}, 32'd0);
        tick();
        rst = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555AAAA;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        check("rb_spur_rdata", read_data_m, 32'd0);
        check("rb_spur_req", {31'b0, dmem_req}, 32'd0);
        check("rb_spur_stall", {31'b0, stall_m}, 32'd0);
        check("rb_spur_regwr", {31'b0, reg_write_m}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
